// File: rtl/divider_if.sv
// divider_if: operand/result bundle shared by the divider and its controller.
//   dividend, divisor  operands, sampled by the divider on an accepted op_start
//   op_start           start request, level-sampled while the divider is idle
//   op_clear           synchronous clear, highest priority
//   quotient/remainder registered results, valid while op_done=1
//   op_done            high while the divider holds a finished result
interface divider_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             op_start;
    logic             op_clear;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             op_done;

    modport master (
        output dividend, divisor, op_start, op_clear,
        input  quotient, remainder, op_done
    );

    modport slave (
        input  dividend, divisor, op_start, op_clear,
        output quotient, remainder, op_done
    );
endinterface

// File: rtl/divider.sv
// divider: sequential unsigned restoring divider, one quotient bit per clock.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      divider_if.slave: operands + op_start/op_clear in,
//            quotient/remainder/op_done out
// A start accepted at edge k runs WIDTH iterations on edges k+1..k+WIDTH and
// publishes the result on edge k+WIDTH+1; the result holds until op_clear.
module divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      reset_n,
    divider_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;      // partial remainder (always < D between steps)
    logic [WIDTH-1:0] q_q, q_d;      // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] d_q, d_d;      // latched divisor
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    // One restoring step. The shifted partial remainder needs WIDTH+1 bits;
    // bit WIDTH of the difference is the borrow, i.e. "T is negative".
    logic [WIDTH:0] a_sh;
    logic [WIDTH:0] t;

    always_comb begin
        a_sh = {a_q, q_q[WIDTH-1]};
        t    = a_sh - {1'b0, d_q};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        q_d     = q_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;

        if (bus.op_clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            a_d     = '0;
            q_d     = '0;
            d_d     = '0;
            quot_d  = '0;
            rem_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.op_start) begin
                        state_d = EXEC;
                        cnt_d   = '0;
                        a_d     = '0;
                        q_d     = bus.dividend;
                        d_d     = bus.divisor;
                    end
                end
                EXEC: begin
                    // After WIDTH steps the registered Q/A are final; this extra
                    // edge publishes them, which is why 2**CNT_W must exceed WIDTH.
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        state_d = DONE;
                        quot_d  = q_q;
                        rem_d   = a_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (!t[WIDTH]) begin
                            a_d = t[WIDTH-1:0];
                            q_d = {q_q[WIDTH-2:0], 1'b1};
                        end else begin
                            a_d = a_sh[WIDTH-1:0];
                            q_d = {q_q[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    // Result registers are only non-zero in DONE, so intermediates never leak.
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.op_done   = (state_q == DONE);
endmodule

// File: tb/tb_divider.sv
module tb_divider;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    divider_if #(.WIDTH(W)) bus ();
    divider #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    vec_t vecs[11];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_op();
        @(negedge clk);
        bus.op_clear = 1'b1;
        @(negedge clk);
        bus.op_clear = 1'b0;
    endtask

    // Start at edge k, check op_done low at k+32 and the result at k+33.
    task automatic run_div(input string name, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                           input logic [W-1:0] eq, input logic [W-1:0] er);
        @(negedge clk);
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.op_start = 1'b1;
        @(posedge clk);
        #1 bus.op_start = 1'b0;
        repeat (32) @(posedge clk);
        @(negedge clk);
        chk({name, " done@32"}, W'(bus.op_done), W'(0));
        chk({name, " quot@32"}, bus.quotient, W'(0));
        @(posedge clk);
        @(negedge clk);
        chk({name, " done@33"}, W'(bus.op_done), W'(1));
        chk({name, " quot"}, bus.quotient, eq);
        chk({name, " rem"}, bus.remainder, er);
    endtask

    initial begin
        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[2]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[3]  = '{32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234};
        vecs[4]  = '{32'd5,          32'd9,          32'd0,          32'd5};
        vecs[5]  = '{32'd1000,       32'd10,         32'd100,        32'd0};
        vecs[6]  = '{32'd0,          32'd5,          32'd0,          32'd0};
        vecs[7]  = '{32'h8000_0000,  32'd3,          32'd715827882,  32'd2};
        vecs[8]  = '{32'd12345678,   32'd1000,       32'd12345,      32'd678};
        vecs[9]  = '{32'd1,          32'd1,          32'd1,          32'd0};
        vecs[10] = '{32'd7,          32'hFFFF_FFFF,  32'd0,          32'd7};

        bus.dividend = '0;
        bus.divisor  = '0;
        bus.op_start = 1'b0;
        bus.op_clear = 1'b0;
        #12;
        chk("reset done", W'(bus.op_done), W'(0));
        chk("reset quot", bus.quotient, W'(0));
        chk("reset rem", bus.remainder, W'(0));
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_div($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r);
            clear_op();
            chk($sformatf("vec%0d cleared", i), W'(bus.op_done), W'(0));
        end

        // 100/7 result holds for 10 cycles
        run_div("hold", 32'd100, 32'd7, 32'd14, 32'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold quot", bus.quotient, 32'd14);
            chk("hold rem", bus.remainder, 32'd2);
            chk("hold done", W'(bus.op_done), W'(1));
        end
        clear_op();

        // Operand change after the start edge is ignored
        @(negedge clk);
        bus.dividend = 32'd5;
        bus.divisor  = 32'd9;
        bus.op_start = 1'b1;
        @(posedge clk);
        #1 bus.op_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.dividend = 32'd50;
        bus.divisor = 32'd3;
        repeat (29) @(posedge clk);
        @(negedge clk);
        chk("opchg done@32", W'(bus.op_done), W'(0));
        @(negedge clk);
        chk("opchg done", W'(bus.op_done), W'(1));
        chk("opchg quot", bus.quotient, 32'd0);
        chk("opchg rem", bus.remainder, 32'd5);
        clear_op();

        // op_clear mid-EXEC aborts, then a clean restart
        @(negedge clk);
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd10;
        bus.op_start = 1'b1;
        @(posedge clk);
        #1 bus.op_start = 1'b0;
        repeat (10) @(posedge clk);
        clear_op();
        chk("abort done", W'(bus.op_done), W'(0));
        chk("abort quot", bus.quotient, W'(0));
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("abort stays idle", W'(bus.op_done), W'(0));
        run_div("restart", 32'd1000, 32'd10, 32'd100, 32'd0);

        // op_start held through DONE: no restart
        repeat (5) @(negedge clk);
        bus.op_start = 1'b1;
        bus.dividend = 32'd77;
        bus.divisor  = 32'd7;
        repeat (5) @(negedge clk);
        chk("held done", W'(bus.op_done), W'(1));
        chk("held quot", bus.quotient, 32'd100);
        // op_clear with op_start=1 -> IDLE, next edge starts 77/7
        bus.op_clear = 1'b1;
        @(negedge clk);
        bus.op_clear = 1'b0;
        chk("clr+start done", W'(bus.op_done), W'(0));
        @(posedge clk);            // start accepted here
        #1 bus.op_start = 1'b0;
        repeat (32) @(posedge clk);
        @(negedge clk);
        chk("restart2 done@32", W'(bus.op_done), W'(0));
        @(negedge clk);
        chk("restart2 done", W'(bus.op_done), W'(1));
        chk("restart2 quot", bus.quotient, 32'd11);
        chk("restart2 rem", bus.remainder, 32'd0);
        clear_op();

        // Simultaneous start and clear in IDLE: start dropped
        @(negedge clk);
        bus.op_start = 1'b1;
        bus.op_clear = 1'b1;
        @(negedge clk);
        bus.op_start = 1'b0;
        bus.op_clear = 1'b0;
        repeat (40) @(negedge clk);
        chk("start+clr dropped", W'(bus.op_done), W'(0));

        // Async reset in DONE clears outputs without a clock edge
        run_div("pre-rst", 32'd9, 32'd2, 32'd4, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async rst done", W'(bus.op_done), W'(0));
        chk("async rst quot", bus.quotient, W'(0));
        chk("async rst rem", bus.remainder, W'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // Async reset mid-EXEC: operation lost, no op_done appears
        @(negedge clk);
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        bus.op_start = 1'b1;
        @(posedge clk);
        #1 bus.op_start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst mid done", W'(bus.op_done), W'(0));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst mid idle", W'(bus.op_done), W'(0));
        run_div("post-rst", 32'd100, 32'd7, 32'd14, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
